// File: rtl/comma_align_10b.sv
// ---------------------------------------------------------------------------
// comma_align_10b
//
// Word aligner placed directly ahead of the 8b/10b decoder. The deserializer
// delivers free-running 10-bit words with an arbitrary bit rotation. This
// block looks for the comma prefix (0011111 or 1100000) at each of the ten
// bit offsets of a 20-bit two-word window. It confirms that the offset is
// stable and then emits re-framed codewords, where bit 9 is the first
// transmitted bit 'a'.
//
// Handshake: in_valid marks a new word on data_in for this cycle. The
// aligner has no back-pressure, so every valid word is consumed. out_valid
// marks a new aligned word on data_out and is high only while LOCKED.
// Nothing advances on a cycle with in_valid low.
//
// Parameters:
//   CONFIRM_COUNT  commas at one offset, including the acquiring one, needed
//                  to lock (2..15)
//   LOSS_COUNT     consecutive foreign-offset commas that drop lock (1..15)
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   data_in     unaligned word, bit 9 received first
//   in_valid    data_in carries a new word
//   data_out    aligned codeword for the decoder
//   out_valid   data_out is a new aligned word and the aligner is LOCKED
//   locked      FSM is in LOCKED
//   offset      current bit offset, 0..9
//   comma_det   data_out is a comma word at the locked offset
//   realign     one-cycle pulse when the offset changes or lock is lost
// ---------------------------------------------------------------------------
module comma_align_10b #(
    parameter int CONFIRM_COUNT = 3,
    parameter int LOSS_COUNT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] data_in,
    input  logic       in_valid,
    output logic [9:0] data_out,
    output logic       out_valid,
    output logic       locked,
    output logic [3:0] offset,
    output logic       comma_det,
    output logic       realign
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [6:0] COMMA_NEG = 7'b0011111;
    localparam logic [6:0] COMMA_POS = 7'b1100000;

    // Registers
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_offset;
    logic [9:0] r_cur;
    logic [9:0] r_prev;
    logic [9:0] r_data_out;
    logic       r_out_valid;
    logic       r_locked;
    logic       r_comma_det;
    logic       r_realign;

    // Combinational signals
    // Window bit 0 is never part of a candidate, so it is left out.
    logic [19:1] w_window;
    logic [9:0]  w_hit;
    logic        w_hit_any;
    logic [3:0]  w_hit_k;
    logic [9:0]  w_cand [10];
    logic [9:0]  w_slice;
    logic        w_hit_at_next;
    state_t      w_next_state;
    logic [3:0]  w_next_cnt;
    logic [3:0]  w_next_offset;
    logic        w_realign;
    logic [3:0]  w_cnt_inc;

    assign w_window  = {r_prev, r_cur[9:1]};
    assign w_cnt_inc = r_cnt + 4'd1;

    // Candidate word and comma detection at every offset k. Candidate k
    // starts k bits into the older word.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < 10; k++) begin
            w_hit[k]  = (w_window[19-k -: 7] == COMMA_NEG) ||
                        (w_window[19-k -: 7] == COMMA_POS);
            w_cand[k] = w_window[19-k -: 10];
        end
    end

    // The lowest offset wins if a window ever holds more than one comma.
    // Scanning downward lets the last match, which is the lowest k, win.
    always_comb begin
        w_hit_any = |w_hit;
        w_hit_k   = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_hit_k = 4'(k);
            end
        end
    end

    // Next-state logic. Hits count only on advancing cycles.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_offset = r_offset;
        w_realign     = 1'b0;
        if (in_valid && w_hit_any) begin
            case (r_state)
                ST_HUNT: begin
                    w_next_offset = w_hit_k;
                    w_next_cnt    = 4'd1;
                    w_realign     = 1'b1;
                    w_next_state  = ST_CONFIRM;
                end
                ST_CONFIRM: begin
                    if (w_hit_k == r_offset) begin
                        if (w_cnt_inc == 4'(CONFIRM_COUNT)) begin
                            // The counter is reused as the foreign-comma count in LOCKED.
                            w_next_state = ST_LOCKED;
                            w_next_cnt   = 4'd0;
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end else begin
                        w_next_offset = w_hit_k;
                        w_next_cnt    = 4'd1;
                        w_realign     = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_hit_k == r_offset) begin
                        w_next_cnt = 4'd0;
                    end else if (w_cnt_inc == 4'(LOSS_COUNT)) begin
                        // The offset is held; HUNT picks the next one.
                        w_next_state = ST_HUNT;
                        w_next_cnt   = 4'd0;
                        w_realign    = 1'b1;
                    end else begin
                        w_next_cnt = w_cnt_inc;
                    end
                end
                default: begin
                    w_next_state = ST_HUNT;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    // Slice at the offset that takes effect on this edge. This lets the
    // acquiring comma word leave already aligned.
    always_comb begin
        w_slice       = w_cand[0];
        w_hit_at_next = w_hit[0];
        for (int k = 1; k < 10; k++) begin
            if (w_next_offset == 4'(k)) begin
                w_slice       = w_cand[k];
                w_hit_at_next = w_hit[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_cnt       <= 4'd0;
            r_offset    <= 4'd0;
            r_cur       <= 10'd0;
            r_prev      <= 10'd0;
            r_data_out  <= 10'd0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_comma_det <= 1'b0;
            r_realign   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_cur      <= data_in;
                r_prev     <= r_cur;
                r_data_out <= w_slice;
            end
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_offset    <= w_next_offset;
            r_out_valid <= in_valid && (w_next_state == ST_LOCKED);
            r_locked    <= (w_next_state == ST_LOCKED);
            r_comma_det <= in_valid && w_hit_at_next && (w_next_state == ST_LOCKED);
            r_realign   <= w_realign;
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign locked    = r_locked;
    assign offset    = r_offset;
    assign comma_det = r_comma_det;
    assign realign   = r_realign;

endmodule

// File: doc/comma_align_10b.md
Name: comma_align_10b

Overview:
- Word aligner that sits directly upstream of the 8b/10b decoder.
- Takes free-running, arbitrarily bit-rotated 10-bit words from the deserializer and searches for the K28.5/K28.1/K28.7 comma (0011111 or 1100000) at every bit offset.
- Confirms a stable offset, then emits re-framed 10-bit codewords (bit 9 = first transmitted bit 'a') plus lock status to the decoder's data_in.

Parameters:
- CONFIRM_COUNT, 3: commas required at the same offset, counting the acquiring one, to enter LOCKED. Legal range 2..15.
- LOSS_COUNT, 4: consecutive commas at a foreign offset, while LOCKED, that force return to HUNT. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- data_in  in  10  unaligned word from deserializer; bit 9 is the earliest received bit
- in_valid  in  1  data_in is a new word this cycle
- data_out  out  10  aligned codeword, feeds the decoder's data_in
- out_valid  out  1  data_out is a new aligned word and the aligner is LOCKED
- locked  out  1  FSM in LOCKED
- offset  out  4  current bit offset, 0..9
- comma_det  out  1  data_out is a comma-bearing word at the locked offset
- realign  out  1  one-cycle pulse when the offset changes or lock is lost

Behaviour:
- Pipeline, advancing only when in_valid=1:
  - cur_q <= data_in; prev_q <= cur_q.
  - window = {prev_q, cur_q}, 20 bits.
  - Candidate at offset k = window[19-k -: 10], k = 0..9.
- Comma detect at k: window[19-k -: 7] == 7'b0011111 or 7'b1100000. hit[k] is evaluated only on advancing cycles.
- Multiple hits in one window: the lowest k wins (cannot occur on a legal stream).
- Latency: a word presented with in_valid at edge E0 appears on data_out after edge E0+2 at offset 0. At offset k>0, data_out combines its last 10-k bits with the first k bits of the next word, at the same edge.
- data_out register loads the window slice at next_offset on every advance. When a comma is acquired, the comma word itself is output already aligned.
- FSM states HUNT, CONFIRM, LOCKED; counter cnt, 4 bits.
  - HUNT, hit at k: offset<=k, cnt<=1, realign pulse, go to CONFIRM.
  - CONFIRM, hit at offset: cnt+1. When cnt+1 == CONFIRM_COUNT, go to LOCKED.
  - CONFIRM, hit at k != offset: offset<=k, cnt<=1, realign pulse, stay in CONFIRM.
  - CONFIRM, no hit: hold.
  - LOCKED, hit at offset: cnt<=0.
  - LOCKED, hit at k != offset: cnt+1. When cnt+1 == LOSS_COUNT: realign pulse, go to HUNT, cnt<=0, offset held.
  - LOCKED, no hit: hold.
- Outputs, all registered and updated on the same edge as the FSM:
  - out_valid <= in_valid & (next_state == LOCKED).
  - locked <= (next_state == LOCKED).
  - comma_det <= in_valid & hit[next_offset] & (next_state == LOCKED).
  - realign: one cycle only.
- in_valid=0: pipeline, FSM, cnt, offset and data_out hold. out_valid, comma_det and realign deassert next cycle; locked holds.
- Reset (any time, including mid-lock): cur_q, prev_q, data_out = 0; offset = 0; cnt = 0; state = HUNT; out_valid, locked, comma_det, realign = 0. The first two advances after reset fill the pipeline; zeros cannot produce a hit.
- No decoding or disparity checking in this block; invalid codewords pass through to the decoder.

Test Plan:
- Repeating pattern K28.5- (0011111010), D21.5 (1010101010), K28.5+ (1100000101), D21.5, rotated by 3 bits, in_valid=1 -> offset=3. realign pulses once at the first comma. locked=1 on the edge registering the 3rd comma. data_out then cycles 0011111010, 1010101010, 1100000101, 1010101010 with comma_det=1 on the K words.
- Same stream unrotated -> offset=0. First aligned word appears 2 edges after input. No realign in CONFIRM.
- After lock at offset 3, switch the stream to offset 7 -> locked stays 1 through 3 foreign commas. On the 4th: realign=1, locked=0, out_valid=0. Lock is then reacquired at offset=7 after 3 more commas.
- While locked, 3 foreign-offset commas then 1 comma at offset 3 -> cnt clears and lock is retained. A further 3 foreign commas still do not unlock.
- Toggle in_valid 1,0,0,1 while locked -> data_out and offset hold, out_valid low for the two idle cycles, locked stays 1, no lost or duplicated word.
- Only D21.5 words (no comma) -> state stays in HUNT and out_valid never asserts. Assert rst mid-lock -> all outputs 0 and offset=0 on the next edge.
